job_control: RTL
================

JOB_CONTROL -- requirements
Module: job_control

Interface
REQ-001 SHALL have parameter RESET_CYCLES, default 8, number of cycles spent in RESETTING before ah_jdone (legal range 1..255).
REQ-002 SHALL have ports:
- clock  input  1  rising-edge clock, driven from ha_pclock.
- reset_n  input  1  asynchronous active-low reset.
- ha_jval  input  1  job command valid.
- ha_jcom  input  [0:7]  job command code.
- ha_jcompar  input  1  odd parity over ha_jcom.
- ha_jea  input  [0:63]  job effective address (WED).
- ha_jeapar  input  1  odd parity over ha_jea.
- ah_jrunning  output  1  job running.
- ah_jdone  output  1  job done, one-cycle pulse.
- ah_jcack  output  1  LLCMD acknowledge, one-cycle pulse.
- ah_jerror  output  [0:63]  job error code, qualified by ah_jdone.
- ah_jyield  output  1  job yield.
- ah_tbreq  output  1  timebase request.
- ah_paren  output  1  parity enable.
- app_start  output  1  one-cycle pulse to AFU core: job begins.
- app_wed  output  [0:63]  WED latched at START.
- app_reset  output  1  held high while RESETTING.
- app_done  input  1  AFU core finished, one-cycle pulse.
- app_error  input  [0:63]  AFU core error code, sampled with app_done.

Function
REQ-003 SHALL decode ha_jcom when ha_jval=1: 8'h90 START, 8'h80 RESET, 8'h45 LLCMD, 8'h42 TIMEBASE; all other codes ignored.
REQ-004 SHALL implement states IDLE, RUNNING, RESETTING.
REQ-005 RESET in any state SHALL enter RESETTING next cycle, clear the counter, assert app_reset and deassert ah_jrunning.
REQ-006 RESETTING SHALL last exactly RESET_CYCLES cycles, then pulse ah_jdone one cycle with ah_jerror=0 and enter IDLE.
REQ-007 START in IDLE SHALL latch ha_jea into app_wed, enter RUNNING; ah_jrunning and app_start both rise the cycle after ha_jval.
REQ-008 START in RUNNING or RESETTING SHALL be ignored with no output change.
REQ-009 app_done in RUNNING SHALL, next cycle, pulse ah_jdone with ah_jerror=app_error, drop ah_jrunning and enter IDLE; app_done outside RUNNING SHALL be ignored.
REQ-010 RESET and app_done in the same cycle: RESET SHALL win; no app-driven ah_jdone.
REQ-011 LLCMD in any state SHALL pulse ah_jcack exactly one cycle, the cycle after ha_jval, without changing state.
REQ-012 TIMEBASE SHALL be accepted and ignored; ah_tbreq and ah_jyield SHALL be constant 0.
REQ-013 ah_jerror SHALL be 0 whenever ah_jdone=0; ah_jdone and ah_jrunning SHALL never both be 1.
REQ-014 All outputs except constant ties SHALL be registered.

Reset
REQ-015 On reset_n=0, asynchronously: state IDLE, counter 0, app_wed 0; ah_jrunning, ah_jdone, ah_jcack, app_start, app_reset 0; ah_jerror 0.
REQ-016 reset_n asserted mid-job SHALL abort without an ah_jdone pulse.

Configuration
REQ-017 With JOB_PARITY_CHECK_EN defined: ah_paren=1; bad ha_jcompar or ha_jeapar on a valid command SHALL discard that command; in RUNNING or IDLE it SHALL pulse ah_jdone next cycle with ah_jerror=64'h1 and enter IDLE. Parity-failed RESET SHALL still be obeyed.
REQ-018 Without JOB_PARITY_CHECK_EN: ah_paren=0; parity inputs unused; no parity-driven ah_jdone.

Structure
REQ-019 A shared package SHALL hold the job command codes, the state enum and the parity-error code constant.
REQ-020 Single module; no sub-module.

Verification
REQ-021 reset_n low, then START jea=64'h1000 -> cycle+1 ah_jrunning=1, app_start pulse, app_wed=64'h1000.
REQ-022 RUNNING, app_done with app_error=64'h5 -> next cycle ah_jdone=1, ah_jerror=64'h5, ah_jrunning=0.
REQ-023 RESET while RUNNING, RESET_CYCLES=8 -> app_reset high 8 cycles, then a single ah_jdone with ah_jerror=0, state IDLE.
REQ-024 LLCMD during RUNNING -> ah_jcack single pulse next cycle, ah_jrunning stays 1.
REQ-025 RESET and app_done same cycle -> no error-carrying ah_jdone; only RESETTING-completion ah_jdone.
REQ-026 JOB_PARITY_CHECK_EN: START with bad ha_jcompar -> ah_jdone with ah_jerror=64'h1, ah_jrunning stays 0.

Source files
------------

// File: rtl/job_control_pkg.sv
// Shared definitions for the job control block: command codes, FSM states,
// the parity-failure error code and the odd-parity helper.
package job_control_pkg;

  localparam logic [7:0]  CMD_START    = 8'h90;
  localparam logic [7:0]  CMD_RESET    = 8'h80;
  localparam logic [7:0]  CMD_LLCMD    = 8'h45;
  localparam logic [7:0]  CMD_TIMEBASE = 8'h42;

  localparam logic [63:0] PARITY_ERR_CODE = 64'h0000_0000_0000_0001;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_RUNNING   = 2'd1,
    ST_RESETTING = 2'd2
  } job_state_e;

  // Odd parity: data plus parity bit must hold an odd number of ones.
  function automatic logic odd_parity_ok(input logic [63:0] data, input logic par);
    return ^{data, par};
  endfunction

endpackage

// File: rtl/job_control.sv
// Job control FSM: decodes host job commands, runs the AFU core and sequences resets.
// Optional command parity checking is enabled by defining JOB_PARITY_CHECK_EN.
module job_control
  import job_control_pkg::*;
#(
  parameter int RESET_CYCLES = 8
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        ha_jval,
  input  logic [0:7]  ha_jcom,
  input  logic        ha_jcompar,
  input  logic [0:63] ha_jea,
  input  logic        ha_jeapar,
  output logic        ah_jrunning,
  output logic        ah_jdone,
  output logic        ah_jcack,
  output logic [0:63] ah_jerror,
  output logic        ah_jyield,
  output logic        ah_tbreq,
  output logic        ah_paren,
  output logic        app_start,
  output logic [0:63] app_wed,
  output logic        app_reset,
  input  logic        app_done,
  input  logic [0:63] app_error
);

  localparam logic [7:0] LAST_CNT = 8'(RESET_CYCLES - 1);

  job_state_e  state_r;
  logic [7:0]  cnt_r;
  logic        jrunning_r;
  logic        jdone_r;
  logic        jcack_r;
  logic [0:63] jerror_r;
  logic        app_start_r;
  logic [0:63] app_wed_r;
  logic        app_reset_r;

  logic        par_bad_s;
  logic        cmd_start_s;
  logic        cmd_reset_s;
  logic        cmd_llcmd_s;

`ifdef JOB_PARITY_CHECK_EN
  assign ah_paren = 1'b1;
`else
  logic unused_parity_s;
  assign unused_parity_s = ^{ha_jcompar, ha_jeapar};
  assign ah_paren = 1'b0;
`endif

  // Command decode; a parity-failed command is discarded except for RESET.
  always_comb begin
    par_bad_s   = 1'b0;
    cmd_start_s = 1'b0;
    cmd_reset_s = 1'b0;
    cmd_llcmd_s = 1'b0;
    if (ha_jval) begin
`ifdef JOB_PARITY_CHECK_EN
      par_bad_s = !(odd_parity_ok({56'h0, ha_jcom}, ha_jcompar) &&
                    odd_parity_ok(ha_jea, ha_jeapar));
`else
      par_bad_s = 1'b0;
`endif
      cmd_reset_s = (ha_jcom == CMD_RESET);
      cmd_start_s = (ha_jcom == CMD_START) && !par_bad_s;
      cmd_llcmd_s = (ha_jcom == CMD_LLCMD) && !par_bad_s;
    end else begin
      par_bad_s = 1'b0;
    end
  end

  // Job state machine with all handshake outputs registered.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_r     <= ST_IDLE;
      cnt_r       <= 8'd0;
      jrunning_r  <= 1'b0;
      jdone_r     <= 1'b0;
      jcack_r     <= 1'b0;
      jerror_r    <= 64'h0;
      app_start_r <= 1'b0;
      app_wed_r   <= 64'h0;
      app_reset_r <= 1'b0;
    end else begin
      jdone_r     <= 1'b0;
      jerror_r    <= 64'h0;
      app_start_r <= 1'b0;
      jcack_r     <= cmd_llcmd_s;
      if (cmd_reset_s) begin
        // RESET overrides everything, including a coincident app_done.
        state_r     <= ST_RESETTING;
        cnt_r       <= 8'd0;
        app_reset_r <= 1'b1;
        jrunning_r  <= 1'b0;
      end else begin
        case (state_r)
          ST_IDLE: begin
            if (par_bad_s) begin
              jdone_r  <= 1'b1;
              jerror_r <= PARITY_ERR_CODE;
            end else if (cmd_start_s) begin
              app_wed_r   <= ha_jea;
              state_r     <= ST_RUNNING;
              jrunning_r  <= 1'b1;
              app_start_r <= 1'b1;
            end
          end
          ST_RUNNING: begin
            if (par_bad_s) begin
              state_r    <= ST_IDLE;
              jrunning_r <= 1'b0;
              jdone_r    <= 1'b1;
              jerror_r   <= PARITY_ERR_CODE;
            end else if (app_done) begin
              state_r    <= ST_IDLE;
              jrunning_r <= 1'b0;
              jdone_r    <= 1'b1;
              jerror_r   <= app_error;
            end
          end
          ST_RESETTING: begin
            if (cnt_r == LAST_CNT) begin
              state_r     <= ST_IDLE;
              app_reset_r <= 1'b0;
              jdone_r     <= 1'b1;
            end else begin
              cnt_r <= cnt_r + 8'd1;
            end
          end
          default: begin
            state_r     <= ST_IDLE;
            cnt_r       <= 8'd0;
            jrunning_r  <= 1'b0;
            app_reset_r <= 1'b0;
          end
        endcase
      end
    end
  end

  assign ah_jrunning = jrunning_r;
  assign ah_jdone    = jdone_r;
  assign ah_jcack    = jcack_r;
  assign ah_jerror   = jerror_r;
  assign ah_jyield   = 1'b0;
  assign ah_tbreq    = 1'b0;
  assign app_start   = app_start_r;
  assign app_wed     = app_wed_r;
  assign app_reset   = app_reset_r;

endmodule
